sound_event_sequencer: RTL and testbench



---
 rtl/sound_event_sequencer_pkg.sv | 17 +
 rtl/sound_event_sequencer_fifo.sv | 57 +++++
 rtl/sound_event_sequencer.sv | 125 ++++++++++++
 tb/tb_sound_event_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_event_sequencer_pkg.sv
// Shared types and constants for the sound event sequencer (package sound_pkg).
package sound_pkg;

  localparam int unsigned SOUND_SAMPLE_BITS = 2;

  localparam int unsigned EVT_PADDLE = 0;
  localparam int unsigned EVT_WALL   = 1;
  localparam int unsigned EVT_BRICK  = 2;
  localparam int unsigned EVT_LOST   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } sound_state_e;

endpackage

// File: rtl/sound_event_sequencer_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rdata whenever not empty.
module sound_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Push is judged against occupancy at cycle start, so a pop never makes room for a same-cycle push.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !RESET) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Game-event strobes to SELECT/TRIGGER command stream for the sample bank.
// Optional SOUND_PREEMPT_EN: a lower-index queued request cuts the current HOLD short.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned EVENT_COUNT = 4,
  parameter int unsigned SAMPLE_BITS = SOUND_SAMPLE_BITS,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned HOLD_CYCLES = 5000000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [EVENT_COUNT-1:0] EVENT,
  output logic [SAMPLE_BITS-1:0] SELECT,
  output logic                   TRIGGER,
  output logic                   BUSY,
  output logic                   DROPPED
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  sound_state_e           state_q, state_d;
  logic [SAMPLE_BITS-1:0] sel_q, sel_d;
  logic                   trig_q, trig_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   drop_q, drop_d;
  logic [EVENT_COUNT-1:0] pending_q, pending_d;

  logic [EVENT_COUNT-1:0] push_mask;
  logic [SAMPLE_BITS-1:0] push_idx;
  logic                   found;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_BITS-1:0] fifo_head;

  sound_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (SAMPLE_BITS)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (fifo_push),
    .wdata (push_idx),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pending stage: lowest set index moves into the FIFO; a strobe on a bit
  // leaving this cycle starts a fresh request instead of being coalesced.
  always_comb begin
    push_mask = '0;
    push_idx  = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < EVENT_COUNT; i++) begin
      if (!found && pending_q[i]) begin
        found        = 1'b1;
        push_mask[i] = 1'b1;
        push_idx     = SAMPLE_BITS'(i);
      end
    end
    fifo_push = found && !fifo_full;
    if (!fifo_push) push_mask = '0;
    pending_d = (pending_q & ~push_mask) | EVENT;
    drop_d    = |(EVENT & pending_q & ~push_mask);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    trig_d   = 1'b0;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sel_d    = fifo_head;
          trig_d   = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
`ifdef SOUND_PREEMPT_EN
        if (!fifo_empty && (fifo_head < sel_q)) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_q != ST_IDLE) || !fifo_empty || (|pending_q) || (|EVENT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      trig_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      trig_q    <= trig_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      pending_q <= pending_d;
    end
  end

  assign SELECT  = sel_q;
  assign TRIGGER = trig_q;
  assign BUSY    = busy_q;
  assign DROPPED = drop_q;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer with HOLD_CYCLES=8 (trigger spacing 10).
module tb_sound_event_sequencer;
  import sound_pkg::*;

  localparam int HOLD  = 8;
  localparam int SPACE = HOLD + 2;
  localparam int NV    = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ev;
  logic [1:0] sel;
  logic       trig, busy, drop;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int trig_cyc[$];
  int trig_sel[$];
  int drop_cyc[$];

  typedef struct {
    logic [3:0] ev;
    int         ntrig;
    logic [7:0] sels;
  } vec_t;

  vec_t vec[NV];

  sound_event_sequencer #(
    .EVENT_COUNT (4),
    .SAMPLE_BITS (2),
    .QUEUE_DEPTH (4),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .EVENT   (ev),
    .SELECT  (sel),
    .TRIGGER (trig),
    .BUSY    (busy),
    .DROPPED (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig) begin
      trig_cyc.push_back(cyc);
      trig_sel.push_back(int'(sel));
    end
    if (drop) drop_cyc.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) step(1);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    trig_cyc.delete();
    trig_sel.delete();
    drop_cyc.delete();
  endtask

  task automatic check_triggers(input string name, input int exp_cyc[$], input int exp_sel[$]);
    check({name, "_count"}, trig_cyc.size(), exp_cyc.size());
    for (int k = 0; k < exp_cyc.size(); k++) begin
      if (k < trig_cyc.size()) begin
        check($sformatf("%s_cyc%0d", name, k), trig_cyc[k], exp_cyc[k]);
        check($sformatf("%s_sel%0d", name, k), trig_sel[k], exp_sel[k]);
      end
    end
  endtask

  initial begin
    int b, last;
    int ec[$];
    int es[$];
    logic [7:0] s;

    vec[0] = '{ev: 4'b0100, ntrig: 1, sels: {2'd0, 2'd0, 2'd0, 2'd2}};
    vec[1] = '{ev: 4'b1011, ntrig: 3, sels: {2'd0, 2'd3, 2'd1, 2'd0}};
    vec[2] = '{ev: 4'b0001, ntrig: 1, sels: {2'd0, 2'd0, 2'd0, 2'd0}};
    vec[3] = '{ev: 4'b1111, ntrig: 4, sels: {2'd3, 2'd2, 2'd1, 2'd0}};
    vec[4] = '{ev: 4'b1000, ntrig: 1, sels: {2'd0, 2'd0, 2'd0, 2'd3}};

    rst = 1'b1;
    ev  = '0;
    step(3);
    check("rst_select", int'(sel), 0);
    check("rst_trigger", int'(trig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(drop), 0);
    rst = 1'b0;
    step(2);

    for (int v = 0; v < NV; v++) begin
      clear_logs();
      check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
      b  = cyc;
      ev = vec[v].ev;
      step(1);
      ev = '0;
      check($sformatf("v%0d_busy_rise", v), int'(busy), 1);
      last = b + 3 + SPACE * (vec[v].ntrig - 1);
      wait_until(last + HOLD);
      check($sformatf("v%0d_busy_hold", v), int'(busy), 1);
      wait_until(last + HOLD + 3);
      check($sformatf("v%0d_busy_fall", v), int'(busy), 0);
      ec.delete();
      es.delete();
      s = vec[v].sels;
      for (int k = 0; k < vec[v].ntrig; k++) begin
        ec.push_back(b + 3 + SPACE * k);
        es.push_back(int'(s[2*k +: 2]));
      end
      check_triggers($sformatf("v%0d_trig", v), ec, es);
      check($sformatf("v%0d_no_drop", v), drop_cyc.size(), 0);
      step(2);
    end

    // Coalesce: bit 1 re-strobed while pending and not the one being pushed.
    clear_logs();
    b  = cyc;
    ev = 4'b0011;
    step(1);
    ev = 4'b0010;
    step(1);
    ev = '0;
    wait_until(b + 3 + SPACE + HOLD + 4);
    check("coal_drop_count", drop_cyc.size(), 1);
    if (drop_cyc.size() > 0) check("coal_drop_cyc", drop_cyc[0], b + 2);
    ec = '{b + 3, b + 3 + SPACE};
    es = '{0, 1};
    check_triggers("coal_trig", ec, es);
    step(2);

    // Seven requests strobed during HOLD overflow the 4-deep queue into pending.
    clear_logs();
    b  = cyc;
    ev = 4'(1 << EVT_LOST);
    step(1);
    ev = '0;
    wait_until(b + 4);
    for (int i = 0; i < 7; i++) begin
      ev = 4'(1 << (i % 4));
      step(1);
    end
    ev = '0;
    wait_until(b + 3 + SPACE * 7 + HOLD + 4);
    ec.delete();
    es = '{3, 0, 1, 2, 3, 0, 1, 2};
    for (int k = 0; k < 8; k++) ec.push_back(b + 3 + SPACE * k);
    check_triggers("burst_trig", ec, es);
    check("burst_no_drop", drop_cyc.size(), 0);
    check("burst_busy_end", int'(busy), 0);
    step(2);

    // Lower index arriving during HOLD of index 3.
    clear_logs();
    b  = cyc;
    ev = 4'(1 << EVT_LOST);
    step(1);
    ev = '0;
    wait_until(b + 7);
    ev = 4'(1 << EVT_PADDLE);
    step(1);
    ev = '0;
    wait_until(b + 40);
`ifdef SOUND_PREEMPT_EN
    ec = '{b + 3, b + 11};
`else
    ec = '{b + 3, b + 13};
`endif
    es = '{3, 0};
    check_triggers("preempt_trig", ec, es);
    step(2);

    // Reset during HOLD with two requests queued; EVENT during reset is ignored.
    clear_logs();
    b  = cyc;
    ev = 4'b0111;
    step(1);
    ev = '0;
    wait_until(b + 6);
    rst = 1'b1;
    ev  = 4'(1 << EVT_LOST);
    step(1);
    rst = 1'b0;
    ev  = '0;
    check("rreset_select", int'(sel), 0);
    check("rreset_trigger", int'(trig), 0);
    check("rreset_busy", int'(busy), 0);
    check("rreset_dropped", int'(drop), 0);
    step(40);
    ec = '{b + 3};
    es = '{0};
    check_triggers("rreset_trig", ec, es);
    check("rreset_busy_after", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
